hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 15 +
 rtl/hazard_perf.sv | 32 +++
 rtl/hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_hazard_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: stage-control codes and FSM states.
package hazard_ctrl_pkg;

   // Stage control: bit0 = hold (dominates), bit1 = flush-to-NOP
   localparam logic [1:0] CTRL_RUN   = 2'b00;
   localparam logic [1:0] CTRL_HOLD  = 2'b01;
   localparam logic [1:0] CTRL_FLUSH = 2'b10;

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_MEM_WAIT = 2'b01,
      ST_FAULT    = 2'b10
   } state_e;

endpackage

// File: rtl/hazard_perf.sv
// Free-running stall/flush event counters; only built when HAZARD_PERF_EN is defined.
module hazard_perf (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall_ev_i,
   input  logic        flush_ev_i,
   output logic [31:0] stall_cnt_o,
   output logic [31:0] flush_cnt_o
);

   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q + {31'd0, stall_ev_i};
      flush_cnt_d = flush_cnt_q + {31'd0, flush_ev_i};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch flushes, data-memory stalls with timeout.
// Define HAZARD_PERF_EN to add the stall_cnt/flush_cnt performance counters.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_uses_rs1,
   input  logic        id_uses_rs2,
   input  logic [4:0]  ex_rd,
   input  logic        ex_is_load,
   input  logic        branch_taken,
   input  logic        mem_req,
   input  logic        mem_ack,
   output logic        pc_hold,
   output logic [1:0]  if_id_ctrl,
   output logic [1:0]  id_ex_ctrl,
   output logic [1:0]  ex_mem_ctrl,
   output logic [1:0]  mem_wb_ctrl,
   output logic        mem_fault
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt
`endif
);

   // The cycle that enters MEM_WAIT counts as the first wait, so the
   // fault fires after MEM_TIMEOUT stalled cycles in total.
   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   state_e     state_q, state_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       pend_flush_q, pend_flush_d;

   logic       load_use;
   logic       mem_stall;
   logic [7:0] wait_nxt;

   assign load_use  = ex_is_load && (ex_rd != 5'd0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));
   assign mem_stall = ((state_q == ST_RUN) && mem_req && !mem_ack) ||
                      ((state_q == ST_MEM_WAIT) && !mem_ack);
   assign wait_nxt  = wait_cnt_q + 8'd1;

   always_comb begin
      state_d      = state_q;
      wait_cnt_d   = wait_cnt_q;
      pend_flush_d = pend_flush_q;
      pc_hold      = 1'b0;
      if_id_ctrl   = CTRL_RUN;
      id_ex_ctrl   = CTRL_RUN;
      ex_mem_ctrl  = CTRL_RUN;
      mem_wb_ctrl  = CTRL_RUN;
      mem_fault    = 1'b0;

      if (state_q == ST_FAULT) begin
         if_id_ctrl   = CTRL_FLUSH;
         id_ex_ctrl   = CTRL_FLUSH;
         ex_mem_ctrl  = CTRL_FLUSH;
         mem_wb_ctrl  = CTRL_FLUSH;
         mem_fault    = 1'b1;
         pend_flush_d = 1'b0;
         wait_cnt_d   = '0;
         state_d      = ST_RUN;
      end else if (mem_stall) begin
         pc_hold     = 1'b1;
         if_id_ctrl  = CTRL_HOLD;
         id_ex_ctrl  = CTRL_HOLD;
         ex_mem_ctrl = CTRL_HOLD;
         mem_wb_ctrl = CTRL_FLUSH;
         if (branch_taken) pend_flush_d = 1'b1;
         if (state_q == ST_MEM_WAIT) begin
            wait_cnt_d = wait_nxt;
            if (wait_nxt == WAIT_LAST) state_d = ST_FAULT;
         end else begin
            wait_cnt_d = '0;
            state_d    = ST_MEM_WAIT;
         end
      end else begin
         if (state_q == ST_MEM_WAIT) begin
            wait_cnt_d = '0;
            state_d    = ST_RUN;
         end
         if (branch_taken || pend_flush_q) begin
            if_id_ctrl   = CTRL_FLUSH;
            id_ex_ctrl   = CTRL_FLUSH;
            pend_flush_d = 1'b0;
         end else if (load_use) begin
            pc_hold    = 1'b1;
            if_id_ctrl = CTRL_HOLD;
            id_ex_ctrl = CTRL_FLUSH;
         end
      end

      if (reset) begin
         pc_hold     = 1'b1;
         if_id_ctrl  = CTRL_FLUSH;
         id_ex_ctrl  = CTRL_FLUSH;
         ex_mem_ctrl = CTRL_FLUSH;
         mem_wb_ctrl = CTRL_FLUSH;
         mem_fault   = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_RUN;
         wait_cnt_q   <= '0;
         pend_flush_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         pend_flush_q <= pend_flush_d;
      end
   end

`ifdef HAZARD_PERF_EN
   hazard_perf u_perf (
      .clock       (clock),
      .reset       (reset),
      .stall_ev_i  (pc_hold),
      .flush_ev_i  (if_id_ctrl == CTRL_FLUSH),
      .stall_cnt_o (stall_cnt),
      .flush_cnt_o (flush_cnt)
   );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl with MEM_TIMEOUT=4.
module tb_hazard_ctrl;

   logic        clock;
   logic        reset;
   logic [4:0]  id_rs1, id_rs2, ex_rd;
   logic        id_uses_rs1, id_uses_rs2, ex_is_load;
   logic        branch_taken, mem_req, mem_ack;
   logic        pc_hold, mem_fault;
   logic [1:0]  if_id_ctrl, id_ex_ctrl, ex_mem_ctrl, mem_wb_ctrl;
`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cnt, flush_cnt;
`endif

   int vectors = 0;
   int miscompares = 0;

   // Expected vector: {pc_hold, if_id, id_ex, ex_mem, mem_wb, mem_fault}
   localparam logic [9:0] E_RST  = 10'b1_10_10_10_10_0;
   localparam logic [9:0] E_IDLE = 10'b0_00_00_00_00_0;
   localparam logic [9:0] E_LU   = 10'b1_01_10_00_00_0;
   localparam logic [9:0] E_FL   = 10'b0_10_10_00_00_0;
   localparam logic [9:0] E_ST   = 10'b1_01_01_01_10_0;
   localparam logic [9:0] E_FT   = 10'b0_10_10_10_10_1;

   logic [9:0] exp_q[$];
   string      tag_q[$];

   hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
      .clock        (clock),
      .reset        (reset),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_uses_rs1  (id_uses_rs1),
      .id_uses_rs2  (id_uses_rs2),
      .ex_rd        (ex_rd),
      .ex_is_load   (ex_is_load),
      .branch_taken (branch_taken),
      .mem_req      (mem_req),
      .mem_ack      (mem_ack),
      .pc_hold      (pc_hold),
      .if_id_ctrl   (if_id_ctrl),
      .id_ex_ctrl   (id_ex_ctrl),
      .ex_mem_ctrl  (ex_mem_ctrl),
      .mem_wb_ctrl  (mem_wb_ctrl),
      .mem_fault    (mem_fault)
`ifdef HAZARD_PERF_EN
      ,
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // One cycle: drive at negedge, queue the expectation, sample 2 time units later.
   task automatic step(input logic rst, input logic ld, input logic [4:0] rd,
                       input logic u1, input logic [4:0] rs1,
                       input logic u2, input logic [4:0] rs2,
                       input logic br, input logic req, input logic ack,
                       input logic [9:0] exp, input string tag);
      logic [9:0] obs, e;
      string      t;
      @(negedge clock);
      reset        = rst;
      ex_is_load   = ld;
      ex_rd        = rd;
      id_uses_rs1  = u1;
      id_rs1       = rs1;
      id_uses_rs2  = u2;
      id_rs2       = rs2;
      branch_taken = br;
      mem_req      = req;
      mem_ack      = ack;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      #2;
      obs = {pc_hold, if_id_ctrl, id_ex_ctrl, ex_mem_ctrl, mem_wb_ctrl, mem_fault};
      e   = exp_q.pop_front();
      t   = tag_q.pop_front();
      vectors++;
      assert (obs === e) else begin
         miscompares++;
         $error("FAIL %s observed=%b expected=%b", t, obs, e);
      end
   endtask

   task automatic idle(input logic req, input logic ack, input logic br,
                       input logic [9:0] exp, input string tag);
      step(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, br, req, ack, exp, tag);
   endtask

   initial begin
      reset = 1'b1; ex_is_load = 1'b0; ex_rd = '0; id_uses_rs1 = 1'b0; id_rs1 = '0;
      id_uses_rs2 = 1'b0; id_rs2 = '0; branch_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;

      step(1'b1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, E_RST, "reset0");
      step(1'b1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, E_RST, "reset1");
      idle(0, 0, 0, E_IDLE, "run_idle");
`ifdef HAZARD_PERF_EN
      vectors++;
      assert (stall_cnt === 32'd0 && flush_cnt === 32'd0) else begin
         miscompares++;
         $error("FAIL perf_after_reset observed=%0d/%0d expected=0/0", stall_cnt, flush_cnt);
      end
`endif

      // Load-use detection
      step(0, 1, 5'd5, 1, 5'd5, 0, 5'd0, 0, 0, 0, E_LU,   "lu_rs1");
      step(0, 1, 5'd0, 1, 5'd0, 0, 5'd0, 0, 0, 0, E_IDLE, "lu_rd0");
      step(0, 1, 5'd7, 0, 5'd7, 1, 5'd7, 0, 0, 0, E_LU,   "lu_rs2");
      step(0, 1, 5'd7, 0, 5'd7, 0, 5'd7, 0, 0, 0, E_IDLE, "lu_unused");
      step(0, 0, 5'd5, 1, 5'd5, 0, 5'd0, 0, 0, 0, E_IDLE, "lu_notload");
      step(0, 1, 5'd5, 1, 5'd5, 0, 5'd0, 1, 0, 0, E_FL,   "branch_over_lu");

      // Plain memory stall: 3 stalled cycles then release
      idle(1, 0, 0, E_ST,   "mst1");
      idle(1, 0, 0, E_ST,   "mst2");
      idle(1, 0, 0, E_ST,   "mst3");
      idle(1, 1, 0, E_IDLE, "mst_release");
      idle(0, 0, 0, E_IDLE, "mst_after");

      // Stall outranks load-use; branch during stall is replayed at release
      step(0, 1, 5'd5, 1, 5'd5, 0, 5'd0, 1, 1, 0, E_ST, "pf_stall_br");
      idle(1, 0, 0, E_ST,   "pf_stall2");
      idle(1, 0, 0, E_ST,   "pf_stall3");
      idle(1, 1, 0, E_FL,   "pf_release_flush");
      idle(0, 0, 0, E_IDLE, "pf_cleared");

      // Timeout: 4 stalled cycles then one fault cycle; pending flush dropped
      idle(1, 0, 0, E_ST,   "to_st1");
      idle(1, 0, 0, E_ST,   "to_st2");
      idle(1, 0, 0, E_ST,   "to_st3");
      idle(1, 0, 1, E_ST,   "to_st4");
      idle(0, 0, 0, E_FT,   "to_fault");
      idle(0, 0, 0, E_IDLE, "to_after_fault");

      // Ack on the timeout cycle wins; load-use evaluated on release
      idle(1, 0, 0, E_ST, "ack4_st1");
      idle(1, 0, 0, E_ST, "ack4_st2");
      idle(1, 0, 0, E_ST, "ack4_st3");
      step(0, 1, 5'd9, 0, 5'd0, 1, 5'd9, 0, 1, 1, E_LU, "ack4_release_lu");
      idle(0, 0, 0, E_IDLE, "ack4_no_fault");

      // Reset mid-wait discards pending flush and timeout progress
      idle(1, 0, 1, E_ST, "rst_st1");
      idle(1, 0, 0, E_ST, "rst_st2");
      step(1'b1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, E_RST, "rst_midwait");
      idle(0, 0, 0, E_IDLE, "rst_no_pending");
`ifdef HAZARD_PERF_EN
      vectors++;
      assert (stall_cnt === 32'd0 && flush_cnt === 32'd0) else begin
         miscompares++;
         $error("FAIL perf_after_midwait_reset observed=%0d/%0d expected=0/0", stall_cnt, flush_cnt);
      end
`endif
      idle(1, 0, 0, E_ST,   "rst_to_st1");
      idle(1, 0, 0, E_ST,   "rst_to_st2");
      idle(1, 0, 0, E_ST,   "rst_to_st3");
      idle(1, 0, 0, E_ST,   "rst_to_st4");
      idle(1, 0, 0, E_FT,   "rst_to_fault");
      idle(0, 0, 0, E_IDLE, "rst_to_run");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
